// File: rtl/ahb3lite_gpio.sv
// ahb3lite_gpio: AHB3-Lite GPIO slave with direction, atomic set/clear, synchronised inputs and rising-edge IRQ
module ahb3lite_gpio #(
  parameter int GPIO_WIDTH = 8,
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int SYNC_STAGES = 2,
  parameter logic [GPIO_WIDTH-1:0] OUT_RST = '0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe_o,
  output logic                  irq_o
);
  typedef enum logic [1:0] {S_OK, S_ERR1, S_ERR2} state_t;
  state_t state;
  logic dp_valid, dp_write, ready_q, resp_q, accept, bad, we, unused;
  logic [2:0] dp_off;
  logic [3:0] dp_lanes, lanes;
  logic [31:0] lane_bits;
  logic [GPIO_WIDTH-1:0] data_out, dir, irq_en, irq_stat, prev, data_in, rise, wmask, wbits, rd;
  logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] sync;
  assign accept = HSEL & HREADY & HTRANS[1];
  assign bad = (HADDR[4:2] == 3'd7) | (HSIZE > 3'd2);
  assign lanes = (HSIZE == 3'd0) ? 4'b0001 << HADDR[1:0] :
                 (HSIZE == 3'd1) ? (HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign lane_bits = {{8{dp_lanes[3]}}, {8{dp_lanes[2]}}, {8{dp_lanes[1]}}, {8{dp_lanes[0]}}};
  assign wmask = lane_bits[GPIO_WIDTH-1:0];
  assign wbits = HWDATA[GPIO_WIDTH-1:0] & wmask;
  assign we = dp_valid & dp_write & HREADY;
  assign data_in = sync[SYNC_STAGES-1];
  assign rise = data_in & ~prev;
  assign rd = (dp_off == 3'd0) ? data_out :
              (dp_off == 3'd3) ? dir :
              (dp_off == 3'd4) ? data_in :
              (dp_off == 3'd5) ? irq_en :
              (dp_off == 3'd6) ? irq_stat : '0;
  assign HRDATA = (dp_valid & ~dp_write) ? HDATA_SIZE'(rd) : '0;
  assign HREADYOUT = ready_q;
  assign HRESP = resp_q;
  assign gpio_o = data_out;
  assign gpio_oe_o = dir;
  assign irq_o = |(irq_stat & irq_en);
  assign unused = ^{HBURST, HPROT, HADDR, HWDATA, HTRANS[0]};
  // Address-phase capture and the two-cycle ERROR response sequencer
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state <= S_OK;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_off <= '0;
      dp_lanes <= '0;
      ready_q <= 1'b1;
      resp_q <= 1'b0;
    end else if (state == S_ERR1) begin
      state <= S_ERR2;
      dp_valid <= 1'b0;
      ready_q <= 1'b1;
      resp_q <= 1'b1;
    end else if (HREADY) begin
      state <= (accept & bad) ? S_ERR1 : S_OK;
      dp_valid <= accept & ~bad;
      dp_write <= HWRITE;
      dp_off <= HADDR[4:2];
      dp_lanes <= lanes;
      ready_q <= ~(accept & bad);
      resp_q <= accept & bad;
    end
  // Input synchroniser and edge history
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      sync <= '0;
      prev <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], gpio_i};
      prev <= data_in;
    end
  // Register writes at the end of the data phase; edge capture beats a same-cycle W1C
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      data_out <= OUT_RST;
      dir <= '0;
      irq_en <= '0;
      irq_stat <= '0;
    end else begin
      data_out <= !we ? data_out :
                  (dp_off == 3'd0) ? (data_out & ~wmask) | wbits :
                  (dp_off == 3'd1) ? data_out | wbits :
                  (dp_off == 3'd2) ? data_out & ~wbits : data_out;
      dir <= (we && dp_off == 3'd3) ? (dir & ~wmask) | wbits : dir;
      irq_en <= (we && dp_off == 3'd5) ? (irq_en & ~wmask) | wbits : irq_en;
      irq_stat <= (irq_stat & ~((we && dp_off == 3'd6) ? wbits : '0)) | rise;
    end
endmodule

// File: tb/tb_ahb3lite_gpio.sv
// tb_ahb3lite_gpio: scoreboard bench for the AHB3-Lite GPIO slave
module tb_ahb3lite_gpio;
  logic HCLK, HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, HRESP, irq_o;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0] HSIZE, HBURST;
  logic [3:0] HPROT;
  logic [1:0] HTRANS;
  logic [7:0] gpio_i, gpio_o, gpio_oe_o;
  logic [31:0] pend_d;
  bit done, mon_dp;
  int checks, failures;
  string b_name[$];
  bit b_rd[$];
  logic [31:0] b_data[$];
  bit b_err[$];
  string p_name[$];
  logic [7:0] p_o[$];
  logic [7:0] p_oe[$];
  bit p_irq[$];
  bit p_bus[$];

  assign HREADY = HREADYOUT;

  ahb3lite_gpio #(.GPIO_WIDTH(8), .OUT_RST(8'h3C)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe_o(gpio_oe_o), .irq_o(irq_o)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic pin(input string nm, input logic [7:0] o, input logic [7:0] oe, input bit irq, input bit bus);
    p_name.push_back(nm); p_o.push_back(o); p_oe.push_back(oe); p_irq.push_back(irq); p_bus.push_back(bus);
  endtask

  task automatic cyc(input logic [1:0] tr, input logic w, input logic [31:0] a, input logic [2:0] sz,
                     input logic [31:0] d, input logic [31:0] exp, input bit err, input string nm);
    int n;
    HSEL = 1'b1; HTRANS = tr; HWRITE = w; HADDR = a; HSIZE = sz; HWDATA = pend_d;
    if (tr[1]) begin
      b_name.push_back(nm); b_rd.push_back(!w); b_data.push_back(exp); b_err.push_back(err);
    end
    n = 0;
    while (!HREADY) begin
      @(posedge HCLK); #1;
      n++;
      if (n > 8) begin
        $display("FAIL %s_timeout: HREADYOUT=%b required 1 within 8 cycles", nm, HREADYOUT);
        $fatal(1, "bus stalled");
      end
    end
    @(posedge HCLK); #1;
    pend_d = d;
  endtask

  task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d, input string nm);
    cyc(2'b10, 1'b1, a, sz, d, 32'h0, 1'b0, nm);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    cyc(2'b10, 1'b0, a, 3'd2, 32'h0, exp, 1'b0, nm);
  endtask

  task automatic idle();
    cyc(2'b00, 1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b0, "idle");
  endtask

  // Monitor: compares bus responses at data-phase ends and pin expectations each cycle
  initial begin
    forever begin
      @(negedge HCLK);
      if (mon_dp) begin
        checks++;
        if (!HREADYOUT) begin
          if (b_name.size() == 0 || !b_err[0] || HRESP !== 1'b1) begin
            failures++;
            $display("FAIL %s_err1: HREADYOUT=%b HRESP=%b required wait state only on ERROR with HRESP=1",
                     (b_name.size() != 0) ? b_name[0] : "none", HREADYOUT, HRESP);
          end
        end else if (b_name.size() == 0) begin
          failures++;
          $display("FAIL bus_unexpected: data phase with no expected entry, HRESP=%b", HRESP);
        end else begin
          string nm;
          bit r, e;
          logic [31:0] x;
          nm = b_name.pop_front(); r = b_rd.pop_front(); x = b_data.pop_front(); e = b_err.pop_front();
          if (HRESP !== e || (r && !e && HRDATA !== x)) begin
            failures++;
            $display("FAIL %s: HRDATA=%h HRESP=%b required HRDATA=%h HRESP=%b", nm, HRDATA, HRESP, r ? x : HRDATA, e);
          end
        end
      end
      if (HREADY) mon_dp = HSEL & HTRANS[1];
      while (p_name.size() != 0) begin
        string nm;
        logic [7:0] o, oe;
        bit q, bus;
        nm = p_name.pop_front(); o = p_o.pop_front(); oe = p_oe.pop_front(); q = p_irq.pop_front(); bus = p_bus.pop_front();
        checks++;
        if (gpio_o !== o || gpio_oe_o !== oe || irq_o !== q ||
            (bus && (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0))) begin
          failures++;
          $display("FAIL %s: gpio_o=%h gpio_oe_o=%h irq_o=%b HREADYOUT=%b HRESP=%b HRDATA=%h required gpio_o=%h gpio_oe_o=%h irq_o=%b%s",
                   nm, gpio_o, gpio_oe_o, irq_o, HREADYOUT, HRESP, HRDATA, o, oe, q, bus ? " HREADYOUT=1 HRESP=0 HRDATA=0" : "");
        end
      end
      if (done) begin
        checks++;
        if (b_name.size() != 0 || p_name.size() != 0) begin
          failures++;
          $display("FAIL leftover: bus=%0d pin=%0d entries unchecked required 0", b_name.size(), p_name.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  // Directed stimulus with hand-computed expectations
  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HSIZE = '0;
    HWDATA = '0; HBURST = '0; HPROT = '0; gpio_i = '0; pend_d = '0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    pin("reset", 8'h3C, 8'h00, 1'b0, 1'b1);
    rd(32'h0C, 32'h00, "rst_dir");
    rd(32'h00, 32'h3C, "rst_out");
    rd(32'h18, 32'h00, "rst_stat");
    wr(32'h00, 3'd2, 32'hA5, "w_out");
    wr(32'h04, 3'd2, 32'h0A, "w_set");
    pin("out_a5", 8'hA5, 8'h00, 1'b0, 1'b0);
    wr(32'h08, 3'd2, 32'h81, "w_clr");
    pin("out_af", 8'hAF, 8'h00, 1'b0, 1'b0);
    rd(32'h00, 32'h2E, "rd_out_2e");
    pin("out_2e", 8'h2E, 8'h00, 1'b0, 1'b0);
    wr(32'h0D, 3'd0, 32'h0000_FF00, "w_dir_lane1");
    wr(32'h0C, 3'd0, 32'h0000_00FF, "w_dir_lane0");
    pin("dir_lane1_ignored", 8'h2E, 8'h00, 1'b0, 1'b0);
    rd(32'h0C, 32'hFF, "rd_dir");
    pin("dir_ff", 8'h2E, 8'hFF, 1'b0, 1'b0);
    wr(32'h06, 3'd1, 32'hFFFF_00FF, "w_set_hi_half");
    wr(32'h04, 3'd1, 32'h0000_0011, "w_set_lo_half");
    pin("set_hi_half_ignored", 8'h2E, 8'hFF, 1'b0, 1'b0);
    rd(32'h00, 32'h3F, "rd_out_3f");
    rd(32'h04, 32'h00, "rd_set_zero");
    wr(32'h14, 3'd2, 32'h08, "w_irq_en");
    rd(32'h14, 32'h08, "rd_irq_en");
    gpio_i = 8'h08;
    rd(32'h10, 32'h00, "din_one_edge");
    rd(32'h10, 32'h08, "din_two_edges");
    pin("irq_not_yet", 8'h3F, 8'hFF, 1'b0, 1'b0);
    rd(32'h18, 32'h08, "stat_set");
    pin("irq_up", 8'h3F, 8'hFF, 1'b1, 1'b0);
    wr(32'h18, 3'd2, 32'h08, "w1c");
    idle();
    pin("irq_cleared", 8'h3F, 8'hFF, 1'b0, 1'b0);
    gpio_i = 8'h00;
    repeat (4) idle();
    gpio_i = 8'h08;
    idle();
    wr(32'h18, 3'd2, 32'h08, "w1c_on_edge");
    idle();
    pin("set_wins", 8'h3F, 8'hFF, 1'b1, 1'b0);
    rd(32'h18, 32'h08, "stat_kept");
    wr(32'h18, 3'd2, 32'h08, "w1c_again");
    rd(32'h18, 32'h00, "stat_clr_raw");
    idle();
    pin("irq_low", 8'h3F, 8'hFF, 1'b0, 1'b0);
    cyc(2'b01, 1'b1, 32'h00, 3'd2, 32'hFF, 32'h0, 1'b0, "busy");
    rd(32'h00, 32'h3F, "busy_no_effect");
    cyc(2'b10, 1'b0, 32'h1C, 3'd2, 32'h0, 32'h0, 1'b1, "rd_unmapped");
    cyc(2'b10, 1'b1, 32'h00, 3'd3, 32'h12, 32'h0, 1'b1, "wr_oversize");
    rd(32'h00, 32'h3F, "out_kept");
    idle();
    pin("after_err", 8'h3F, 8'hFF, 1'b0, 1'b0);
    wr(32'h00, 3'd2, 32'h55, "w_lost");
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = pend_d; HRESETn = 1'b0;
    pin("async_rst", 8'h3C, 8'h00, 1'b0, 1'b1);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    rd(32'h00, 32'h3C, "rd_after_rst");
    rd(32'h0C, 32'h00, "dir_after_rst");
    idle();
    pin("post_rst", 8'h3C, 8'h00, 1'b0, 1'b0);
    repeat (2) idle();
    done = 1'b1;
  end
endmodule
